// File: rtl/bythoven_pkg.sv
// ============================================================================
// bythoven_pkg : shared widths, opcodes and fetch-state encoding
// Revision     : 1.0
// ============================================================================
`default_nettype none

package bythoven_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    localparam logic [3:0] OP_END   = 4'b0000;
    localparam logic [3:0] OP_BPM   = 4'b0001;
    localparam int         NOTE_BIT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO with flush; push while full succeeds on pop
// Revision  : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = store[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                store[wr_ptr] <= wr_data;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ins_prefetch.sv
// ============================================================================
// ins_prefetch : SRAM instruction fetcher feeding a valid/ready FIFO
// Revision     : 1.0
// ============================================================================
`default_nettype none

module ins_prefetch #(
    parameter int ADDR_W      = bythoven_pkg::ADDR_W,
    parameter int DATA_W      = bythoven_pkg::DATA_W,
    parameter int DEPTH       = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W-1:0] START_ADDR,
    output logic [ADDR_W-1:0] SRAM_A,
    input  logic [DATA_W-1:0] SRAM_D,
    output logic [DATA_W-1:0] INS,
    output logic [ADDR_W-1:0] INS_PC,
    output logic              INS_VALID,
    input  logic              INS_READY,
    output logic              BUSY,
    output logic              DONE
);

    import bythoven_pkg::*;

    localparam int WC_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic [WC_W-1:0]    wait_cnt;
    logic               done_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_rd;
    logic               handshake;
    logic               pop;
    logic               at_wait;
    logic               fetch_push;
    logic               word_is_end;

    assign handshake   = INS_VALID && INS_READY;
    // START flushes the FIFO, so a pop racing it must not advance anything
    assign pop         = handshake && !START;
    assign at_wait     = (wait_cnt == WC_W'(WAIT_CYCLES));
    assign fetch_push  = (state == FETCH) && at_wait && (!fifo_full || handshake) && !START;
    assign word_is_end = (SRAM_D[DATA_W-1 -: 4] == OP_END);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (fetch_push),
        .pop     (pop),
        .flush   (START),
        .wr_data ({pc, SRAM_D}),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign INS_PC    = fifo_rd[ENTRY_W-1 -: ADDR_W];
    assign INS       = fifo_rd[DATA_W-1:0];
    assign INS_VALID = !fifo_empty;
    assign BUSY      = (state == FETCH);
    assign DONE      = done_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            pc       <= '0;
            SRAM_A   <= '0;
            wait_cnt <= '0;
            done_q   <= 1'b0;
        end else if (START) begin
            state    <= FETCH;
            pc       <= START_ADDR;
            SRAM_A   <= START_ADDR;
            wait_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            if (pop && (INS[DATA_W-1 -: 4] == OP_END)) begin
                done_q <= 1'b1;
            end
            case (state)
                IDLE: ;
                FETCH: begin
                    if (!at_wait) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else if (fetch_push) begin
                        pc       <= pc + 1'b1;
                        SRAM_A   <= pc + 1'b1;
                        wait_cnt <= '0;
                        if (word_is_end) begin
                            state <= HALT;
                        end
                    end
                end
                HALT: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ins_prefetch.sv
// ============================================================================
// tb_ins_prefetch : directed self-checking bench for ins_prefetch
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_ins_prefetch;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [17:0] START_ADDR;
    logic [17:0] SRAM_A;
    logic [15:0] SRAM_D;
    logic [15:0] INS;
    logic [17:0] INS_PC;
    logic        INS_VALID;
    logic        INS_READY;
    logic        BUSY;
    logic        DONE;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:262143];

    assign SRAM_D = mem[SRAM_A];

    ins_prefetch dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .START_ADDR (START_ADDR),
        .SRAM_A     (SRAM_A),
        .SRAM_D     (SRAM_D),
        .INS        (INS),
        .INS_PC     (INS_PC),
        .INS_VALID  (INS_VALID),
        .INS_READY  (INS_READY),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic start_pulse(input logic [17:0] addr);
        START      = 1'b1;
        START_ADDR = addr;
        step(1);
        START      = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        step(3);
        checks++;
        if (SRAM_A !== 18'h0 || INS_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: SRAM_A=%h VALID=%b BUSY=%b DONE=%b required 0/0/0/0", SRAM_A, INS_VALID, BUSY, DONE);
        end
        checks++;
        if (INS !== 16'h0 || INS_PC !== 18'h0) begin
            errors++;
            $display("FAIL reset_ins: INS=%h INS_PC=%h required 0000/00000", INS, INS_PC);
        end
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++;
            if (SRAM_A !== 18'h0 || INS_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
                errors++;
                $display("FAIL idle_cycle%0d: SRAM_A=%h VALID=%b BUSY=%b DONE=%b required 0/0/0/0", i, SRAM_A, INS_VALID, BUSY, DONE);
            end
        end
    endtask

    task automatic test_streaming;
        INS_READY = 1'b1;
        start_pulse(18'h10);
        checks++;
        if (SRAM_A !== 18'h10 || INS_VALID !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL stream_start: SRAM_A=%h VALID=%b BUSY=%b required 00010/0/1", SRAM_A, INS_VALID, BUSY);
        end
        step(2);
        checks++;
        if (INS_VALID !== 1'b0) begin
            errors++;
            $display("FAIL stream_early: VALID=%b required 0", INS_VALID);
        end
        step(1);
        checks++;
        if (INS_VALID !== 1'b1 || INS !== 16'h8100 || INS_PC !== 18'h10 || SRAM_A !== 18'h11) begin
            errors++;
            $display("FAIL stream_first: VALID=%b INS=%h PC=%h SRAM_A=%h required 1/8100/00010/00011", INS_VALID, INS, INS_PC, SRAM_A);
        end
        step(1);
        checks++;
        if (INS_VALID !== 1'b0) begin
            errors++;
            $display("FAIL stream_popped: VALID=%b required 0", INS_VALID);
        end
        step(2);
        checks++;
        if (INS_VALID !== 1'b1 || INS !== 16'h8101 || INS_PC !== 18'h11 || SRAM_A !== 18'h12) begin
            errors++;
            $display("FAIL stream_second: VALID=%b INS=%h PC=%h SRAM_A=%h required 1/8101/00011/00012", INS_VALID, INS, INS_PC, SRAM_A);
        end
    endtask

    task automatic test_backpressure;
        INS_READY = 1'b0;
        start_pulse(18'h10);
        step(22);
        checks++;
        if (SRAM_A !== 18'h14 || INS_VALID !== 1'b1 || INS !== 16'h8100 || INS_PC !== 18'h10) begin
            errors++;
            $display("FAIL bp_full: SRAM_A=%h VALID=%b INS=%h PC=%h required 00014/1/8100/00010", SRAM_A, INS_VALID, INS, INS_PC);
        end
        INS_READY = 1'b1;
        step(1);
        checks++;
        if (SRAM_A !== 18'h15) begin
            errors++;
            $display("FAIL bp_resume: SRAM_A=%h required 00015", SRAM_A);
        end
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) step(1);
            checks++;
            if (INS_VALID !== 1'b1 || INS !== 16'h8100 + 16'(i) || INS_PC !== 18'h10 + 18'(i)) begin
                errors++;
                $display("FAIL bp_order%0d: VALID=%b INS=%h PC=%h required 1/%h/%h", i, INS_VALID, INS, INS_PC, 16'h8100 + 16'(i), 18'h10 + 18'(i));
            end
        end
    endtask

    task automatic test_end;
        INS_READY = 1'b0;
        start_pulse(18'h0);
        step(14);
        checks++;
        if (SRAM_A !== 18'h3 || BUSY !== 1'b0 || INS_VALID !== 1'b1 || INS !== 16'h1060 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL end_halt: SRAM_A=%h BUSY=%b VALID=%b INS=%h DONE=%b required 00003/0/1/1060/0", SRAM_A, BUSY, INS_VALID, INS, DONE);
        end
        INS_READY = 1'b1;
        step(1);
        checks++;
        if (INS !== 16'h8123 || INS_PC !== 18'h1 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL end_word1: INS=%h PC=%h DONE=%b required 8123/00001/0", INS, INS_PC, DONE);
        end
        step(1);
        checks++;
        if (INS_VALID !== 1'b1 || INS !== 16'h0000 || INS_PC !== 18'h2 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL end_word2: VALID=%b INS=%h PC=%h DONE=%b required 1/0000/00002/0", INS_VALID, INS, INS_PC, DONE);
        end
        step(1);
        checks++;
        if (DONE !== 1'b1 || INS_VALID !== 1'b0) begin
            errors++;
            $display("FAIL end_done: DONE=%b VALID=%b required 1/0", DONE, INS_VALID);
        end
        step(10);
        checks++;
        if (DONE !== 1'b1 || INS_VALID !== 1'b0 || SRAM_A !== 18'h3 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL end_hold: DONE=%b VALID=%b SRAM_A=%h BUSY=%b required 1/0/00003/0", DONE, INS_VALID, SRAM_A, BUSY);
        end
    endtask

    task automatic test_wrap_restart;
        INS_READY = 1'b0;
        start_pulse(18'h3FFFF);
        checks++;
        if (DONE !== 1'b0 || SRAM_A !== 18'h3FFFF) begin
            errors++;
            $display("FAIL wrap_start: DONE=%b SRAM_A=%h required 0/3ffff", DONE, SRAM_A);
        end
        step(6);
        checks++;
        if (INS_PC !== 18'h3FFFF || INS !== 16'hA000 || SRAM_A !== 18'h1) begin
            errors++;
            $display("FAIL wrap_first: PC=%h INS=%h SRAM_A=%h required 3ffff/a000/00001", INS_PC, INS, SRAM_A);
        end
        INS_READY = 1'b1;
        step(1);
        INS_READY = 1'b0;
        checks++;
        if (INS_PC !== 18'h0 || INS !== 16'h1060 || INS_VALID !== 1'b1) begin
            errors++;
            $display("FAIL wrap_second: PC=%h INS=%h VALID=%b required 00000/1060/1", INS_PC, INS, INS_VALID);
        end
        step(2);
        INS_READY = 1'b1;
        start_pulse(18'h200);
        checks++;
        if (INS_VALID !== 1'b0 || DONE !== 1'b0 || SRAM_A !== 18'h200 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL restart_flush: VALID=%b DONE=%b SRAM_A=%h BUSY=%b required 0/0/00200/1", INS_VALID, DONE, SRAM_A, BUSY);
        end
        INS_READY = 1'b0;
        step(3);
        checks++;
        if (INS_VALID !== 1'b1 || INS_PC !== 18'h200 || INS !== 16'h7777) begin
            errors++;
            $display("FAIL restart_first: VALID=%b PC=%h INS=%h required 1/00200/7777", INS_VALID, INS_PC, INS);
        end
    endtask

    task automatic test_async_reset;
        INS_READY = 1'b0;
        start_pulse(18'h10);
        step(7);
        checks++;
        if (INS_VALID !== 1'b1 || SRAM_A !== 18'h12) begin
            errors++;
            $display("FAIL arst_pre: VALID=%b SRAM_A=%h required 1/00012", INS_VALID, SRAM_A);
        end
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (SRAM_A !== 18'h0 || INS_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || INS !== 16'h0 || INS_PC !== 18'h0) begin
            errors++;
            $display("FAIL arst_now: SRAM_A=%h VALID=%b BUSY=%b DONE=%b INS=%h PC=%h required all 0", SRAM_A, INS_VALID, BUSY, DONE, INS, INS_PC);
        end
        step(1);
        RST = 1'b0;
        step(5);
        checks++;
        if (SRAM_A !== 18'h0 || INS_VALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL arst_after: SRAM_A=%h VALID=%b BUSY=%b required 0/0/0", SRAM_A, INS_VALID, BUSY);
        end
    endtask

    initial begin
        for (int a = 0; a < 262144; a++) begin
            mem[a] = 16'hFFFF;
        end
        for (int i = 0; i < 8; i++) begin
            mem[18'h10 + i] = 16'h8100 + 16'(i);
        end
        mem[18'h0]     = 16'h1060;
        mem[18'h1]     = 16'h8123;
        mem[18'h2]     = 16'h0000;
        mem[18'h3]     = 16'h9999;
        mem[18'h3FFFF] = 16'hA000;
        mem[18'h200]   = 16'h7777;

        RST        = 1'b1;
        START      = 1'b0;
        START_ADDR = 18'h0;
        INS_READY  = 1'b0;

        test_reset();
        test_streaming();
        test_backpressure();
        test_end();
        test_wrap_restart();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
